// File: rtl/truth_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweep stage.
package truth_sweep_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Default number of function inputs and the resulting vector count
    localparam int unsigned N_IN_DFLT = 4;
    localparam int unsigned NVEC      = 2**N_IN_DFLT;

    // Width of a hold counter that must reach h-1; never narrower than 1 bit
    function automatic int unsigned hold_w(input int unsigned h);
        return (h <= 2) ? 1 : $clog2(h);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Free-running settle interval counter: counts 0..HOLD-1 while enabled and
// flags the final cycle of each interval.
module settle_timer
    import truth_sweep_pkg::*;
#(
    parameter int unsigned HOLD = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned      W        = hold_w(HOLD);
    localparam logic [W-1:0]     LAST_CNT = W'(HOLD - 1);

    logic [W-1:0] hold_cnt;

    // Count within the interval, wrapping to 0 after the last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (clr) begin
            hold_cnt <= '0;
        end else if (en) begin
            if (last) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + W'(1);
            end
        end
    end

    assign last = (hold_cnt == LAST_CNT);

endmodule

// File: rtl/truth_sweep.sv
// Stimulus/capture stage: steps every input vector in ascending order, holds
// each for HOLD cycles, samples f on the last cycle and builds the truth table.
module truth_sweep
    import truth_sweep_pkg::*;
#(
    parameter int unsigned           N_IN   = N_IN_DFLT,
    parameter int unsigned           HOLD   = 10,
    parameter logic [2**N_IN-1:0]    EXP_TT = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 f,
    output logic [N_IN-1:0]      vec,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   tt,
    output logic [N_IN:0]        ones,
    output logic                 pass
);

    state_t               state_q, state_d;
    logic [N_IN-1:0]      vec_q, vec_d;
    logic [2**N_IN-1:0]   tt_q, tt_d;
    logic [N_IN:0]        ones_q, ones_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tmr_clr, tmr_en, tmr_last;

    settle_timer #(
        .HOLD (HOLD)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .last  (tmr_last)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, capture and timer control; abort outranks a same-edge sample
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        busy_d  = busy_q;
        done_d  = done_q;
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SWEEP;
                    vec_d   = '0;
                    tt_d    = '0;
                    ones_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            SWEEP: begin
                tmr_clr = abort;
                tmr_en  = !abort;
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    vec_d   = '0;
                end else if (tmr_last) begin
                    tt_d[vec_q] = f;
                    ones_d      = ones_q + {{N_IN{1'b0}}, f};
                    if (vec_q == '1) begin
                        // busy drops on the final sample so done lands one cycle later
                        state_d = FINISH;
                        busy_d  = 1'b0;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                vec_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vec  = vec_q;
    assign busy = busy_q;
    assign done = done_q;
    assign tt   = tt_q;
    assign ones = ones_q;
    assign pass = done_q && (tt_q == EXP_TT);

endmodule
